// File: rtl/wb_data_select_buf.sv
// Write-back data selector feeding a 2-entry valid/ready skid buffer.
// Optional illegal-selector trapping is enabled by defining WB_SEL_ERR_CHECK_EN.
module wb_data_select_buf #(
  parameter int          WIDTH     = 32,
  parameter int          N_SRC     = 8,
  parameter int          SEL_W     = 4,
  parameter int unsigned CONST_VAL = 227
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SEL_W-1:0]       sel,
  input  logic [N_SRC*WIDTH-1:0] data_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [SEL_W-1:0]       out_sel,
  output logic                   sel_err,
  output logic [7:0]             err_cnt
);

  localparam logic [SEL_W-1:0] SEL_CONST = SEL_W'(N_SRC);

  logic [WIDTH-1:0] mem_data [2];
  logic [SEL_W-1:0] mem_sel  [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic [WIDTH-1:0] sel_data;
  logic             accept;
  logic             do_push;
  logic             do_pop;

  // Illegal selectors fall through to zero data.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (sel == SEL_W'(k)) sel_data = data_in[k*WIDTH +: WIDTH];
    end
    if (sel == SEL_CONST) sel_data = WIDTH'(CONST_VAL);
  end

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = mem_data[rd_ptr];
  assign out_sel   = mem_sel[rd_ptr];

  assign accept = in_valid && in_ready && !flush;
  assign do_pop = out_valid && out_ready && !flush;

`ifdef WB_SEL_ERR_CHECK_EN
  logic       sel_legal;
  logic       sel_err_q;
  logic [7:0] err_cnt_q;

  assign sel_legal = (sel <= SEL_CONST);
  assign do_push   = accept && sel_legal;

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_err_q <= 1'b0;
      err_cnt_q <= 8'd0;
    end else if (accept && !sel_legal) begin
      sel_err_q <= 1'b1;
      if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign sel_err = sel_err_q;
  assign err_cnt = err_cnt_q;
`else
  assign do_push = accept;
  assign sel_err = 1'b0;
  assign err_cnt = 8'd0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      mem_data <= '{default: '0};
      mem_sel  <= '{default: '0};
    end else if (flush) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (do_push) begin
        mem_data[wr_ptr] <= sel_data;
        mem_sel[wr_ptr]  <= sel;
        wr_ptr           <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_data_select_buf.sv
// Directed bench for wb_data_select_buf; covers both builds of WB_SEL_ERR_CHECK_EN.
module tb_wb_data_select_buf;
  localparam int WIDTH = 32;
  localparam int N_SRC = 8;
  localparam int SEL_W = 4;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic [SEL_W-1:0]       sel;
  logic [N_SRC*WIDTH-1:0] data_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_data;
  logic [SEL_W-1:0]       out_sel;
  logic                   sel_err;
  logic [7:0]             err_cnt;

  int n_cmp = 0;
  int n_err = 0;

  wb_data_select_buf #(.WIDTH(WIDTH), .N_SRC(N_SRC), .SEL_W(SEL_W), .CONST_VAL(227)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sel(out_sel), .sel_err(sel_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int k, input logic [WIDTH-1:0] v);
    data_in[k*WIDTH +: WIDTH] = v;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sel = '0;
    data_in = '0;
    tick(); tick();
    reset = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    n_cmp++; if (out_sel !== 4'h0) begin n_err++; $display("FAIL reset_out_sel: got %h want 0", out_sel); end
    n_cmp++; if (sel_err !== 1'b0) begin n_err++; $display("FAIL reset_sel_err: got %b want 0", sel_err); end
    n_cmp++; if (err_cnt !== 8'd0) begin n_err++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
  endtask

  task automatic test_single();
    set_src(3, 32'hDEADBEEF);
    out_ready = 1'b1; sel = 4'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_data: got %h want deadbeef", out_data); end
    n_cmp++; if (out_sel !== 4'd3) begin n_err++; $display("FAIL single_sel: got %0d want 3", out_sel); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_const();
    out_ready = 1'b1; sel = 4'd8; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_data !== 32'h000000E3) begin n_err++; $display("FAIL const_data: got %h want 000000e3", out_data); end
    n_cmp++; if (out_sel !== 4'd8) begin n_err++; $display("FAIL const_sel: got %0d want 8", out_sel); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL const_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    set_src(0, 32'hAAAA0001); set_src(1, 32'hBBBB0002); set_src(2, 32'hCCCC0003);
    out_ready = 1'b0;
    sel = 4'd0; in_valid = 1'b1; tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready1: got %b want 1", in_ready); end
    sel = 4'd1; tick();
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_full: got %b want 0", in_ready); end
    n_cmp++; if (out_data !== 32'hAAAA0001) begin n_err++; $display("FAIL b2b_headA: got %h want aaaa0001", out_data); end
    sel = 4'd2; tick();
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_stallC: got %b want 0", in_ready); end
    n_cmp++; if (out_data !== 32'hAAAA0001) begin n_err++; $display("FAIL b2b_holdA: got %h want aaaa0001", out_data); end
    out_ready = 1'b1; tick();
    n_cmp++; if (out_data !== 32'hBBBB0002) begin n_err++; $display("FAIL b2b_headB: got %h want bbbb0002", out_data); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready2: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_data !== 32'hCCCC0003) begin n_err++; $display("FAIL b2b_headC: got %h want cccc0003", out_data); end
    n_cmp++; if (out_sel !== 4'd2) begin n_err++; $display("FAIL b2b_selC: got %0d want 2", out_sel); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_push_pop();
    set_src(4, 32'h12345678); set_src(5, 32'h0D0D0D0D);
    out_ready = 1'b0; sel = 4'd4; in_valid = 1'b1; tick();
    out_ready = 1'b1; sel = 4'd5; tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL pp_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 32'h0D0D0D0D) begin n_err++; $display("FAIL pp_headD: got %h want 0d0d0d0d", out_data); end
    n_cmp++; if (out_sel !== 4'd5) begin n_err++; $display("FAIL pp_sel: got %0d want 5", out_sel); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL pp_count1: got %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    set_src(6, 32'h66666666); set_src(7, 32'h77777777);
    out_ready = 1'b0; sel = 4'd6; in_valid = 1'b1; tick(); tick();
    flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_full_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_full_ready: got %b want 1", in_ready); end
    in_valid = 1'b1; tick();
    flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_push_lost: got %b want 0", out_valid); end
    sel = 4'd7; in_valid = 1'b1; tick();
    in_valid = 1'b0;
    n_cmp++; if (out_data !== 32'h77777777) begin n_err++; $display("FAIL flush_after_data: got %h want 77777777", out_data); end
    n_cmp++; if (out_sel !== 4'd7) begin n_err++; $display("FAIL flush_after_sel: got %0d want 7", out_sel); end
    out_ready = 1'b1; tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_after_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; sel = 4'd1; in_valid = 1'b1; tick(); tick();
    in_valid = 1'b0; reset = 1'b1; flush = 1'b1; tick();
    reset = 1'b0; flush = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL rstmid_data: got %h want 0", out_data); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_illegal_sel();
    out_ready = 1'b1; sel = 4'd12; in_valid = 1'b1;
`ifdef WB_SEL_ERR_CHECK_EN
    for (int i = 0; i < 3; i++) tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL illegal_no_valid: got %b want 0", out_valid); end
    n_cmp++; if (sel_err !== 1'b1) begin n_err++; $display("FAIL illegal_sel_err: got %b want 1", sel_err); end
    n_cmp++; if (err_cnt !== 8'd3) begin n_err++; $display("FAIL illegal_cnt3: got %0d want 3", err_cnt); end
    for (int i = 0; i < 300; i++) tick();
    n_cmp++; if (err_cnt !== 8'd255) begin n_err++; $display("FAIL illegal_cnt_sat: got %0d want 255", err_cnt); end
    sel = 4'd3; tick();
    in_valid = 1'b0;
    n_cmp++; if (out_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL illegal_then_legal: got %h want deadbeef", out_data); end
    flush = 1'b1; tick();
    flush = 1'b0;
    n_cmp++; if (sel_err !== 1'b1) begin n_err++; $display("FAIL illegal_flush_keeps: got %b want 1", sel_err); end
`else
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL illegal_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL illegal_data: got %h want 0", out_data); end
    n_cmp++; if (out_sel !== 4'd12) begin n_err++; $display("FAIL illegal_sel: got %0d want 12", out_sel); end
    n_cmp++; if (sel_err !== 1'b0) begin n_err++; $display("FAIL illegal_sel_err: got %b want 0", sel_err); end
    n_cmp++; if (err_cnt !== 8'd0) begin n_err++; $display("FAIL illegal_err_cnt: got %0d want 0", err_cnt); end
    tick();
`endif
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL illegal_end_empty: got %b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_const();
    test_back_to_back();
    test_push_pop();
    test_flush();
    test_reset_mid();
    test_illegal_sel();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
